// File: rtl/counter_fsm_pkg.sv
// Shared types and constants for the up/down counter FSM.
package counter_fsm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10,
      TURN = 2'b11
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/updown_step.sv
// Combinational next-count and wrap-flag generator for the up/down counter.
module updown_step
   import counter_fsm_pkg::*;
#(
   parameter int unsigned WIDTH     = 3,
   parameter int unsigned MAX_COUNT = 7,
   parameter bit          SATURATE  = 1'b0
) (
   input  logic [WIDTH-1:0] count_i,
   input  logic             dir_i,
   input  logic             step_i,
   output logic [WIDTH-1:0] next_o,
   output logic             wrap_o
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

   always_comb begin
      next_o = count_i;
      wrap_o = 1'b0;
      if (step_i) begin
         if (dir_i == DIR_UP) begin
            // >= guards against ever exceeding the terminal count
            if (count_i >= MaxVal) begin
               if (SATURATE) begin
                  next_o = MaxVal;
               end else begin
                  next_o = '0;
                  wrap_o = 1'b1;
               end
            end else begin
               next_o = count_i + WIDTH'(1);
            end
         end else begin
            if (count_i == '0) begin
               if (!SATURATE) begin
                  next_o = MaxVal;
                  wrap_o = 1'b1;
               end
            end else begin
               next_o = count_i - WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: rtl/counter_fsm_updown.sv
// Parametrised up/down counter FSM with turnaround state, load and wrap pulse.
// Optional wrap counter output enabled by defining COUNTER_FSM_WRAP_CNT_EN.
module counter_fsm_updown
   import counter_fsm_pkg::*;
#(
   parameter int unsigned WIDTH     = 3,
   parameter int unsigned MAX_COUNT = 7,
   parameter bit          SATURATE  = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             x,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             z,
   output logic             dir,
   output logic             wrap
`ifdef COUNTER_FSM_WRAP_CNT_EN
   ,
   output logic [7:0]       wrap_cnt
`endif
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

   if (longint'(MAX_COUNT) > (longint'(1) << WIDTH) - 1) begin : g_bad_max
      $error("MAX_COUNT does not fit in WIDTH bits");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             wrap_q, wrap_d;
   logic             step_en;
   logic             step_dir;
   logic [WIDTH-1:0] step_next;
   logic             step_wrap;

   assign step_dir = (state_q == DOWN) ? DIR_DOWN : DIR_UP;

   updown_step #(
      .WIDTH     (WIDTH),
      .MAX_COUNT (MAX_COUNT),
      .SATURATE  (SATURATE)
   ) u_step (
      .count_i (count_q),
      .dir_i   (step_dir),
      .step_i  (step_en),
      .next_o  (step_next),
      .wrap_o  (step_wrap)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      dir_d   = dir_q;
      wrap_d  = 1'b0;
      step_en = 1'b0;
      if (load) begin
         count_d = (load_val > MaxVal) ? MaxVal : load_val;
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE, TURN: begin
               if (en) begin
                  state_d = x ? DOWN : UP;
                  dir_d   = x;
               end else begin
                  state_d = IDLE;
               end
            end
            UP, DOWN: begin
               if (!en) begin
                  state_d = IDLE;
               end else if (x != step_dir) begin
                  state_d = TURN;
               end else begin
                  step_en = 1'b1;
                  count_d = step_next;
                  wrap_d  = step_wrap;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
         dir_q   <= DIR_UP;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         dir_q   <= dir_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count = count_q;
   assign dir   = dir_q;
   assign wrap  = wrap_q;
   assign z     = ((state_q == UP) && (count_q == MaxVal)) ||
                  ((state_q == DOWN) && (count_q == '0));

`ifdef COUNTER_FSM_WRAP_CNT_EN
   logic [7:0] wrap_cnt_q, wrap_cnt_d;

   always_comb begin
      wrap_cnt_d = wrap_cnt_q;
      if (load) begin
         wrap_cnt_d = '0;
      end else if (wrap_d && (wrap_cnt_q != 8'hFF)) begin
         wrap_cnt_d = wrap_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wrap_cnt_q <= '0;
      end else begin
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_counter_fsm_updown.sv
// Directed-vector bench: one wrapping and one saturating counter (MAX_COUNT = 5).
module tb_counter_fsm_updown;
   import counter_fsm_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       x = 1'b0;
   logic       load = 1'b0;
   logic [2:0] load_val = '0;

   logic [2:0] w_count, s_count;
   logic       w_z, w_dir, w_wrap, s_z, s_dir, s_wrap;
`ifdef COUNTER_FSM_WRAP_CNT_EN
   logic [7:0] w_wc, s_wc;
`endif

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   counter_fsm_updown #(.WIDTH(3), .MAX_COUNT(5), .SATURATE(1'b0)) dut_w (
      .clock    (clock),
      .reset    (reset),
      .en       (en),
      .x        (x),
      .load     (load),
      .load_val (load_val),
      .count    (w_count),
      .z        (w_z),
      .dir      (w_dir),
      .wrap     (w_wrap)
`ifdef COUNTER_FSM_WRAP_CNT_EN
      ,
      .wrap_cnt (w_wc)
`endif
   );

   counter_fsm_updown #(.WIDTH(3), .MAX_COUNT(5), .SATURATE(1'b1)) dut_s (
      .clock    (clock),
      .reset    (reset),
      .en       (en),
      .x        (x),
      .load     (load),
      .load_val (load_val),
      .count    (s_count),
      .z        (s_z),
      .dir      (s_dir),
      .wrap     (s_wrap)
`ifdef COUNTER_FSM_WRAP_CNT_EN
      ,
      .wrap_cnt (s_wc)
`endif
   );

   typedef struct {
      logic       en;
      logic       x;
      logic       ld;
      logic [2:0] lv;
      logic [2:0] cnt;
      logic       z;
      logic       dir;
      logic       wrap;
      logic [1:0] st;
      logic [7:0] wc;
   } vec_t;

   vec_t vecs[30];

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_w(input int idx, input logic [2:0] c, input logic zz, input logic d,
                          input logic wr, input logic [1:0] st);
      chk("w_count", idx, 32'(w_count), 32'(c));
      chk("w_z", idx, 32'(w_z), 32'(zz));
      chk("w_dir", idx, 32'(w_dir), 32'(d));
      chk("w_wrap", idx, 32'(w_wrap), 32'(wr));
      chk("w_state", idx, 32'(dut_w.state_q), 32'(st));
   endtask

   task automatic check_s(input int idx, input logic [2:0] c, input logic zz, input logic d,
                          input logic wr, input logic [1:0] st);
      chk("s_count", idx, 32'(s_count), 32'(c));
      chk("s_z", idx, 32'(s_z), 32'(zz));
      chk("s_dir", idx, 32'(s_dir), 32'(d));
      chk("s_wrap", idx, 32'(s_wrap), 32'(wr));
      chk("s_state", idx, 32'(dut_s.state_q), 32'(st));
   endtask

   task automatic do_reset();
      en = 1'b0; x = 1'b0; load = 1'b0; load_val = '0;
      #2 reset = 1'b0;
      #3 reset = 1'b1;
      #1;
   endtask

   initial begin
      // en, x, ld, lv, cnt, z, dir, wrap, state, wrap_cnt
      vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, UP, 0};
      vecs[1]  = '{1, 0, 0, 0, 1, 0, 0, 0, UP, 0};
      vecs[2]  = '{1, 0, 0, 0, 2, 0, 0, 0, UP, 0};
      vecs[3]  = '{1, 0, 0, 0, 3, 0, 0, 0, UP, 0};
      vecs[4]  = '{1, 0, 0, 0, 4, 0, 0, 0, UP, 0};
      vecs[5]  = '{1, 0, 0, 0, 5, 1, 0, 0, UP, 0};
      vecs[6]  = '{1, 0, 0, 0, 0, 0, 0, 1, UP, 1};
      vecs[7]  = '{1, 0, 0, 0, 1, 0, 0, 0, UP, 1};
      vecs[8]  = '{1, 0, 0, 0, 2, 0, 0, 0, UP, 1};
      vecs[9]  = '{1, 0, 0, 0, 3, 0, 0, 0, UP, 1};
      vecs[10] = '{1, 1, 0, 0, 3, 0, 0, 0, TURN, 1};
      vecs[11] = '{1, 1, 0, 0, 3, 0, 1, 0, DOWN, 1};
      vecs[12] = '{1, 1, 0, 0, 2, 0, 1, 0, DOWN, 1};
      vecs[13] = '{1, 1, 0, 0, 1, 0, 1, 0, DOWN, 1};
      vecs[14] = '{1, 1, 0, 0, 0, 1, 1, 0, DOWN, 1};
      vecs[15] = '{1, 1, 0, 0, 5, 0, 1, 1, DOWN, 2};
      vecs[16] = '{1, 1, 0, 0, 4, 0, 1, 0, DOWN, 2};
      vecs[17] = '{0, 1, 0, 0, 4, 0, 1, 0, IDLE, 2};
      vecs[18] = '{1, 0, 1, 7, 5, 0, 1, 0, IDLE, 0};
      vecs[19] = '{1, 0, 0, 0, 5, 1, 0, 0, UP, 0};
      vecs[20] = '{1, 0, 0, 0, 0, 0, 0, 1, UP, 1};
      vecs[21] = '{1, 0, 0, 0, 1, 0, 0, 0, UP, 1};
      vecs[22] = '{1, 0, 0, 0, 2, 0, 0, 0, UP, 1};
      vecs[23] = '{1, 0, 1, 7, 5, 0, 0, 0, IDLE, 0};
      vecs[24] = '{1, 0, 0, 0, 5, 1, 0, 0, UP, 0};
      vecs[25] = '{0, 0, 1, 3, 3, 0, 0, 0, IDLE, 0};
      vecs[26] = '{0, 0, 1, 2, 2, 0, 0, 0, IDLE, 0};
      vecs[27] = '{1, 1, 0, 0, 2, 0, 1, 0, DOWN, 0};
      vecs[28] = '{1, 0, 0, 0, 2, 0, 1, 0, TURN, 0};
      vecs[29] = '{0, 0, 0, 0, 2, 0, 1, 0, IDLE, 0};

      do_reset();
      check_w(100, 3'd0, 1'b0, 1'b0, 1'b0, IDLE);

      for (int i = 0; i < 30; i++) begin
         en = vecs[i].en; x = vecs[i].x; load = vecs[i].ld; load_val = vecs[i].lv;
         tick();
         check_w(i, vecs[i].cnt, vecs[i].z, vecs[i].dir, vecs[i].wrap, vecs[i].st);
`ifdef COUNTER_FSM_WRAP_CNT_EN
         chk("w_wrap_cnt", i, 32'(w_wc), 32'(vecs[i].wc));
`endif
      end

      // Asynchronous reset mid-count, no clock edge in between
      do_reset();
      en = 1'b1; x = 1'b0;
      repeat (4) tick();
      check_w(200, 3'd3, 1'b0, 1'b0, 1'b0, UP);
      #2 reset = 1'b0;
      #1 check_w(201, 3'd0, 1'b0, 1'b0, 1'b0, IDLE);
      en = 1'b0;
      #4 reset = 1'b1;

      // Saturation up then down
      do_reset();
      en = 1'b1; x = 1'b0;
      tick();
      check_s(300, 3'd0, 1'b0, 1'b0, 1'b0, UP);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check_s(300 + i, 3'(i), (i == 5), 1'b0, 1'b0, UP);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         check_s(310 + i, 3'd5, 1'b1, 1'b0, 1'b0, UP);
      end
      x = 1'b1;
      tick();
      check_s(320, 3'd5, 1'b0, 1'b0, 1'b0, TURN);
      tick();
      check_s(321, 3'd5, 1'b0, 1'b1, 1'b0, DOWN);
      for (int i = 4; i >= 0; i--) begin
         tick();
         check_s(330 + i, 3'(i), (i == 0), 1'b1, 1'b0, DOWN);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         check_s(340 + i, 3'd0, 1'b1, 1'b1, 1'b0, DOWN);
      end

      // Three up-wraps, then load clears the wrap counter
      do_reset();
      en = 1'b1; x = 1'b0;
      repeat (19) tick();
      check_w(400, 3'd0, 1'b0, 1'b0, 1'b1, UP);
`ifdef COUNTER_FSM_WRAP_CNT_EN
      chk("w_wrap_cnt", 400, 32'(w_wc), 32'd3);
`endif
      load = 1'b1; load_val = 3'd4;
      tick();
      check_w(401, 3'd4, 1'b0, 1'b0, 1'b0, IDLE);
`ifdef COUNTER_FSM_WRAP_CNT_EN
      chk("w_wrap_cnt", 401, 32'(w_wc), 32'd0);
`endif
      load = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
